// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit MIPS fetch/decode path.
package cpu_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam logic [PC_W-1:0] PC_STEP = 16'd4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both as the instruction buffer and as the in-flight address queue.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  logic [W-1:0]           din_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [W-1:0]           head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word reads, buffers returned words and hands {ir, ir_pc} to decode.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] PC_STEP    = cpu_pkg::PC_STEP,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUTST  = 2
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    input  logic               ir_ready
);
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   drop_q, drop_d;
    logic            armed_q;

    logic [CW-1:0]              ibuf_count;
    logic [PC_W+INSTR_W-1:0]    ibuf_head;
    logic [OW-1:0]              aq_count;
    logic [PC_W-1:0]            aq_head;
    logic                       issue;
    logic                       push;
    logic                       pop;

    // armed_q holds the request low for the first cycle after reset so it comes out registered-zero.
    assign imem_req  = armed_q && (state_q == RUN)
                       && (int'(outst_q) + int'(ibuf_count) < FIFO_DEPTH)
                       && (int'(outst_q) < MAX_OUTST);
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req & imem_ready;
    assign push      = imem_rvalid && !redirect && (drop_q == '0);
    assign pop       = ir_valid & ir_ready;
    assign ir_valid  = (ibuf_count != '0);
    assign ir_pc     = ibuf_head[PC_W+INSTR_W-1:INSTR_W];
    assign ir        = ibuf_head[INSTR_W-1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + OW'(issue) - OW'(imem_rvalid);
        drop_d     = drop_q;
        if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        if ((state_q == DRAIN) && (drop_d == '0)) begin
            state_d = RUN;
        end
        // Everything still in flight after this cycle, including a same-cycle issue, is discarded.
        if (redirect) begin
            fetch_pc_d = redirect_pc & 16'hFFFC;
            drop_d     = outst_d;
            state_d    = (outst_d != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            armed_q    <= 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(PC_W + INSTR_W)) u_ibuf (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect),
        .din_i   ({aq_head, imem_rdata}),
        .count_o (ibuf_count),
        .head_o  (ibuf_head)
    );

    // Address of every in-flight request, popped in step with its response.
    fetch_fifo #(.DEPTH(MAX_OUTST), .W(PC_W)) u_addrq (
        .clock   (clock),
        .reset   (reset),
        .push_i  (issue),
        .pop_i   (imem_rvalid),
        .clear_i (1'b0),
        .din_i   (fetch_pc_q),
        .count_o (aq_count),
        .head_o  (aq_head)
    );

    a_outst_underflow: assert property (@(posedge clock) disable iff (reset)
        imem_rvalid |-> (outst_q != '0));
    a_drop_bound: assert property (@(posedge clock) disable iff (reset)
        drop_q <= outst_q);
    a_addrq_tracks: assert property (@(posedge clock) disable iff (reset)
        aq_count == outst_q);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based model of the fetch rules.
module tb_instr_fetch_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready;

    instr_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready)
    );

    always #5 clock = ~clock;

    typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
    typedef struct { logic [15:0] addr; int due; } mreq_t;

    ent_t        m_fifo[$];
    logic [15:0] m_addrq[$];
    mreq_t       memq[$];
    logic [15:0] m_pc;
    int          m_outst, m_drop;
    bit          m_armed, m_known;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int k_ready, k_irready, k_redir, k_maxlat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        logic [15:0] idx;
        idx = addr >> 2;
        return (idx * 16'd40503) ^ 16'h1D2B;
    endfunction

    function automatic bit model_req();
        return m_armed && (m_drop == 0) && (m_outst + m_fifo.size() < 2) && (m_outst < 2);
    endfunction

    task automatic compare_outputs();
        check_eq("imem_req", 32'(imem_req), 32'(model_req()));
        check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
        check_eq("ir_valid", 32'(ir_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            check_eq("ir", 32'(ir), 32'(m_fifo[0].instr));
            check_eq("ir_pc", 32'(ir_pc), 32'(m_fifo[0].pc));
        end else if (!m_armed) begin
            check_eq("ir_rst", 32'(ir), 32'h0);
            check_eq("ir_pc_rst", 32'(ir_pc), 32'h0);
        end
    endtask

    task automatic model_step();
        bit          req;
        logic [15:0] a;
        if (reset) begin
            m_pc    = 16'h0000;
            m_outst = 0;
            m_drop  = 0;
            m_armed = 0;
            m_fifo.delete();
            m_addrq.delete();
            return;
        end
        req = model_req();
        if (m_fifo.size() > 0 && ir_ready) void'(m_fifo.pop_front());
        if (imem_rvalid) begin
            a = m_addrq.pop_front();
            m_outst--;
            if (!redirect) begin
                if (m_drop > 0) m_drop--;
                else m_fifo.push_back('{pc: a, instr: imem_rdata});
            end
        end
        if (req && imem_ready) begin
            m_addrq.push_back(m_pc);
            m_outst++;
            m_pc = m_pc + 16'd4;
        end
        if (redirect) begin
            m_fifo.delete();
            m_pc   = redirect_pc & 16'hFFFC;
            m_drop = m_outst;
        end
        m_armed = 1;
    endtask

    task automatic cycle(input bit rst_in, input bit force_redir, input logic [15:0] force_pc);
        @(negedge clock);
        if (m_known) compare_outputs();
        reset       = rst_in;
        redirect    = force_redir || ($urandom_range(99) < k_redir);
        redirect_pc = force_redir ? force_pc
                    : ($urandom_range(3) == 0) ? (16'hFFF0 | 16'($urandom_range(15)))
                    : 16'($urandom);
        ir_ready    = ($urandom_range(99) < k_irready);
        imem_ready  = ($urandom_range(99) < k_ready);
        imem_rdata  = 16'($urandom);
        imem_rvalid = 1'b0;
        if (rst_in) begin
            memq.delete();
        end else begin
            if (memq.size() > 0 && memq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(memq[0].addr);
                void'(memq.pop_front());
            end
            if (model_req() && imem_ready)
                memq.push_back('{addr: m_pc, due: cyc + int'($urandom_range(k_maxlat, 1))});
        end
        model_step();
        m_known = 1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        m_known = 0;
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
        k_ready = 100; k_irready = 100; k_redir = 0; k_maxlat = 1;
        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0);
        run(30);
        k_irready = 0;
        run(8);
        k_irready = 100;
        run(20);
        k_maxlat = 3;
        run(6);
        cycle(1'b0, 1'b1, 16'h0042);
        run(20);
        k_maxlat = 1;
        cycle(1'b0, 1'b1, 16'hFFF8);
        run(20);
        k_ready = 70; k_irready = 60; k_redir = 4; k_maxlat = 4;
        run(3000);
        cycle(1'b1, 1'b1, 16'h1234);
        run(20);
        k_ready = 90; k_irready = 80; k_redir = 8; k_maxlat = 2;
        run(1500);
        @(negedge clock);
        compare_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
